phy_tx_striper: RTL and testbench
=================================

// Module: phy_tx_striper
// PURPOSE
//  Parametrised PHY TX byte striper, successor to the fixed 32-bit/2-lane TX path.
//  Buffers DATA_W-bit words in a DEPTH-entry FIFO with valid/ready backpressure.
//  Stripes bytes MSB-first across LANES byte lanes, one byte per lane per clock.
//  Runtime x1 mode collapses traffic onto lane 0; idle lanes carry IDLE_SYM.
// PARAMETERS
//  DATA_W    32     input word width; DATA_W/8 (BYTES) must be a multiple of LANES
//  LANES     2      number of 8-bit output lanes (1..BYTES)
//  DEPTH     4      word FIFO depth, power of 2, >=2
//  IDLE_SYM  8'hBC  byte driven on any lane whose valid_out bit is 0
// PORTS
//  clk_32f     in   1                  single clock, rising edge
//  reset       in   1                  asynchronous, active-low; 0 = held in reset
//  data_in     in   DATA_W             input word
//  valid_in    in   1                  data_in valid
//  ready_in    out  1                  FIFO can accept a word; transfer = valid_in & ready_in at edge
//  x1_mode     in   1                  1 = stripe whole word onto lane 0 only
//  data_out    out  LANES*8            lane l on [8l+7:8l], registered
//  valid_out   out  LANES              per-lane byte valid, registered
//  fifo_count  out  $clog2(DEPTH+1)    words held in FIFO (excludes word being serialised)
//  busy        out  1                  serialiser holds a word (registered)
// BEHAVIOUR
//  Reset (reset=0, async): FIFO emptied, fifo_count=0, beat counter=0, busy=0,
//   valid_out=0, data_out={LANES{IDLE_SYM}}. ready_in=1 (combinational, !full).
//   Reset mid-word: partial word and all FIFO contents discarded, no further beats.
//  FIFO: push on valid_in&ready_in; ready_in = (fifo_count!=DEPTH). No write-through
//   when full. Push and pop on same edge: count unchanged. Pointers wrap mod DEPTH.
//  Serialiser states: IDLE, SEND.
//   IDLE: if FIFO non-empty, pop head, latch word and x1_mode, go SEND; beat 0 is
//    registered on this same edge.
//   SEND: one beat per edge. Last beat: if FIFO non-empty, pop next word and emit its
//    beat 0 on the following edge (zero bubble); else go IDLE.
//  Byte index: byte 0 = data_in[DATA_W-1:DATA_W-8], byte i = next lower byte.
//  Normal mode: BEATS = BYTES/LANES; beat k drives lane l with byte k*LANES+l;
//   valid_out = all ones.
//  x1 mode: BEATS = BYTES; beat k drives lane 0 with byte k; valid_out = 1;
//   lanes 1..LANES-1 show IDLE_SYM.
//  x1_mode is sampled only when a word is popped; changes mid-word have no effect.
//  When no beat is emitted: valid_out=0, all lanes IDLE_SYM.
//  Latency: word accepted at edge t into empty FIFO with serialiser IDLE -> beat 0
//   visible after edge t+1, beat k after edge t+1+k.
//  Throughput: 1 word / BEATS clocks; ready_in stays high at a sustained rate <= that.
//  busy = 1 from pop edge until edge after last beat when no next word follows.
// TESTING
//  1. Reset low, then high; 32'hFFDD_FFDD once -> 2 beats: lanes {1,0}={DD,FF},{DD,FF},
//     valid_out=2'b11, then 2'b00/BC BC.
//  2. Back-to-back FFDD_FFDD, EEAA_EEAA, DDFF_AABB, CABF_FABC -> 8 contiguous beats
//     with no bubble; beats 5-6 lane0=DD,AA lane1=FF,BB.
//  3. x1_mode=1, word 32'hCABF_FABC -> lane0 CA,BF,FA,BC over 4 clocks, valid_out=2'b01;
//     lane1 = BC throughout.
//  4. Hold valid_in high with 8 words, DEPTH=4 -> ready_in drops when fifo_count=4,
//     no word lost or duplicated; output order matches input order.
//  5. Assert reset mid-word (after beat 0) -> outputs idle immediately, fifo_count=0,
//     next accepted word starts at beat 0.
//  6. Re-run 2 with DATA_W=64, LANES=4 -> 2 beats per word, lane l = byte k*4+l.

Source files
------------

// File: rtl/phy_tx_striper.sv
// Byte striper for the PHY TX path: buffers DATA_W-bit words in a small FIFO and
// spreads their bytes MSB-first over LANES byte lanes, with a runtime x1 fallback.
module phy_tx_striper #(
    parameter int         DATA_W   = 32,
    parameter int         LANES    = 2,
    parameter int         DEPTH    = 4,
    parameter logic [7:0] IDLE_SYM = 8'hBC
) (
    input  logic                       clk_32f,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  logic                       x1_mode,
    output logic [LANES*8-1:0]         data_out,
    output logic [LANES-1:0]           valid_out,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int BEATS = BYTES / LANES;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [IDX_W-1:0] LAST_N  = IDX_W'(BEATS - 1);
    localparam logic [IDX_W-1:0] LAST_X1 = IDX_W'(BYTES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              empty;
    logic              full;
    logic [DATA_W-1:0] head;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] word_reg;
    logic              x1_reg;
    logic [IDX_W-1:0]  beat_idx;
    logic [IDX_W-1:0]  last_idx;
    logic              load;
    logic              advance;

    logic [DATA_W-1:0] src_word;
    logic              src_x1;
    logic [IDX_W-1:0]  src_idx;
    logic [LANES*8-1:0] beat_data;
    logic [LANES-1:0]  beat_valid;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign ready_in   = !full;
    assign push       = valid_in && !full;
    assign fifo_count = count;
    assign head       = mem[rd_ptr];

    // Storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk_32f) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A pop on the last beat loads the next word directly, so words run back to back.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        last_idx   = x1_reg ? LAST_X1 : LAST_N;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (beat_idx == last_idx) begin
                    if (!empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
        endcase
    end

    // Builds the beat that the next edge will register; beat 0 comes straight from the FIFO head.
    always_comb begin
        src_word   = load ? head : word_reg;
        src_x1     = load ? x1_mode : x1_reg;
        src_idx    = load ? '0 : beat_idx + 1'b1;
        beat_data  = {LANES{IDLE_SYM}};
        beat_valid = '0;
        if (load || advance) begin
            if (src_x1) begin
                beat_valid = LANES'(1);
            end else begin
                beat_valid = '1;
            end
            for (int b = 0; b < BYTES; b++) begin
                if (src_x1) begin
                    if (b == int'(src_idx)) begin
                        beat_data[7:0] = src_word[DATA_W-1-8*b -: 8];
                    end
                end else if ((b / LANES) == int'(src_idx)) begin
                    beat_data[8*(b % LANES) +: 8] = src_word[DATA_W-1-8*b -: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            word_reg  <= '0;
            x1_reg    <= 1'b0;
            beat_idx  <= '0;
            busy      <= 1'b0;
            data_out  <= {LANES{IDLE_SYM}};
            valid_out <= '0;
        end else begin
            if (load) begin
                word_reg <= head;
                x1_reg   <= x1_mode;
                beat_idx <= '0;
            end else if (advance) begin
                beat_idx <= beat_idx + 1'b1;
            end
            busy      <= (state_next == SEND);
            data_out  <= beat_data;
            valid_out <= beat_valid;
        end
    end

endmodule

// File: tb/tb_phy_tx_striper.sv
// Scoreboard bench for phy_tx_striper: a 32-bit/2-lane instance under directed and random
// traffic with a cycle-accurate word model, plus a 64-bit/4-lane instance under back-to-back traffic.
`timescale 1ns/1ps
module tb_phy_tx_striper;

    localparam int         DEPTH = 4;
    localparam logic [7:0] IDLE  = 8'hBC;

    typedef struct {
        logic [63:0] w;
        int          acc;
    } word_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  valid;
    } beat_t;

    logic        clk_32f = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_in;
    logic        x1_mode;
    logic [15:0] data_out;
    logic [1:0]  valid_out;
    logic [2:0]  fifo_count;
    logic        busy;

    logic [63:0] data_in_b;
    logic        valid_in_b;
    logic        ready_in_b;
    logic        x1_mode_b;
    logic [31:0] data_out_b;
    logic [3:0]  valid_out_b;
    logic [2:0]  fifo_count_b;
    logic        busy_b;

    word_t wq[$];
    beat_t eb[$];
    beat_t qb[$];
    int    cyc = 0;
    int    prev_end = 0;
    bit    x1_prev = 1'b0;
    bit    b_active = 1'b0;
    bit    saw_full;
    int    n_checks = 0;
    int    n_fail = 0;

    always #5 clk_32f = ~clk_32f;

    phy_tx_striper #(.DATA_W(32), .LANES(2), .DEPTH(DEPTH), .IDLE_SYM(IDLE)) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .x1_mode    (x1_mode),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    phy_tx_striper #(.DATA_W(64), .LANES(4), .DEPTH(DEPTH), .IDLE_SYM(IDLE)) dut_b (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in_b),
        .valid_in   (valid_in_b),
        .ready_in   (ready_in_b),
        .x1_mode    (x1_mode_b),
        .data_out   (data_out_b),
        .valid_out  (valid_out_b),
        .fifo_count (fifo_count_b),
        .busy       (busy_b)
    );

    // Lanes of beat k for a word split into bytes, byte 0 being the most significant.
    function automatic logic [31:0] exp_lane_word(input logic [63:0] w, input int nbytes,
                                                  input int lanes, input bit x1, input int k);
        logic [7:0]  bytes_a [8];
        logic [31:0] r;
        for (int i = 0; i < 8; i++) bytes_a[i] = 8'h00;
        for (int i = 0; i < nbytes; i++) bytes_a[i] = 8'((w >> (8 * (nbytes - 1 - i))) & 64'hFF);
        r = '0;
        for (int l = 0; l < lanes; l++) begin
            if (x1) r[8*l +: 8] = (l == 0) ? bytes_a[k] : IDLE;
            else    r[8*l +: 8] = bytes_a[k * lanes + l];
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_32f) begin
        cyc++;
        x1_prev = x1_mode;
        if (reset && valid_in && ready_in) wq.push_back('{{32'h0, data_in}, cyc});
        if (reset && valid_in_b && ready_in_b)
            for (int k = 0; k < 2; k++) qb.push_back('{exp_lane_word(data_in_b, 8, 4, 1'b0, k), 4'hF});
    end

    // A word starts one edge after it is accepted, but never before the previous word's last beat has gone.
    always @(negedge clk_32f) begin
        beat_t b;
        word_t w;
        int    st;
        int    nb;
        if (!reset) begin
            check_output("rst_valid", valid_out, 0);
            check_output("rst_data", data_out, 16'hBCBC);
            check_output("rst_count", fifo_count, 0);
            check_output("rst_busy", busy, 0);
            check_output("rst_ready", ready_in, 1);
        end else begin
            if (eb.size() == 0 && wq.size() != 0) begin
                st = (wq[0].acc + 1 > prev_end + 1) ? wq[0].acc + 1 : prev_end + 1;
                if (st <= cyc) begin
                    w  = wq.pop_front();
                    nb = x1_prev ? 4 : 2;
                    for (int k = 0; k < nb; k++)
                        eb.push_back('{exp_lane_word(w.w, 4, 2, x1_prev, k), (x1_prev ? 4'h1 : 4'h3)});
                end
            end
            check_output("fifo_count", fifo_count, wq.size());
            check_output("ready_in", ready_in, wq.size() != DEPTH);
            check_output("busy", busy, eb.size() != 0);
            if (eb.size() != 0) begin
                b = eb.pop_front();
                check_output("beat_valid", valid_out, b.valid);
                check_output("beat_data", data_out, b.data);
                if (eb.size() == 0) prev_end = cyc;
            end else begin
                check_output("idle_valid", valid_out, 0);
                check_output("idle_data", data_out, 16'hBCBC);
            end
        end
    end

    always @(negedge clk_32f) begin
        beat_t b;
        if (reset) begin
            if (valid_out_b != 0) begin
                if (qb.size() == 0) begin
                    check_output("b_extra_beat", valid_out_b, 0);
                end else begin
                    b = qb.pop_front();
                    check_output("b_valid", valid_out_b, b.valid);
                    check_output("b_data", data_out_b, b.data);
                    check_output("b_busy", busy_b, 1);
                    b_active = (qb.size() != 0);
                end
            end else begin
                check_output("b_idle_data", data_out_b, 32'hBCBC_BCBC);
                if (b_active) check_output("b_bubble", valid_out_b, 4'hF);
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] w, input bit hold);
        bit ok;
        ok = 1'b0;
        data_in  = w;
        valid_in = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk_32f);
            if (ready_in) begin
                ok = 1'b1;
                break;
            end
            saw_full = 1'b1;
        end
        check_output("ready_wait", ok, 1);
        @(posedge clk_32f);
        #1;
        if (!hold) valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk_32f);
            if (wq.size() == 0 && eb.size() == 0 && qb.size() == 0 && !busy && !busy_b) begin
                done = 1'b1;
                break;
            end
        end
        check_output("drain", done, 1);
        @(negedge clk_32f);
        #1;
    endtask

    initial begin
        bit seen;
        logic [31:0] burst [4];
        burst[0] = 32'hFFDD_FFDD;
        burst[1] = 32'hEEAA_EEAA;
        burst[2] = 32'hDDFF_AABB;
        burst[3] = 32'hCABF_FABC;
        reset = 1'b1;
        valid_in = 1'b0;
        data_in = '0;
        x1_mode = 1'b0;
        valid_in_b = 1'b0;
        data_in_b = '0;
        x1_mode_b = 1'b0;
        saw_full = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk_32f);
        #1 reset = 1'b1;
        @(posedge clk_32f);
        #1;

        $display("[TB] single word");
        apply_stimulus(32'hFFDD_FFDD, 1'b0);
        wait_idle();

        $display("[TB] back-to-back words");
        for (int i = 0; i < 4; i++) apply_stimulus(burst[i], i < 3);
        wait_idle();

        $display("[TB] x1 mode");
        x1_mode = 1'b1;
        apply_stimulus(32'hCABF_FABC, 1'b0);
        @(posedge clk_32f);
        #1 x1_mode = 1'b0;
        wait_idle();

        $display("[TB] backpressure burst");
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) apply_stimulus($urandom, i < 7);
        check_output("full_seen", saw_full, 1);
        wait_idle();

        $display("[TB] reset mid-word");
        apply_stimulus(32'h1234_5678, 1'b1);
        apply_stimulus(32'h9ABC_DEF0, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (valid_out != 0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_32f);
        end
        check_output("beat0_seen", seen, 1);
        #1 reset = 1'b0;
        wq.delete();
        eb.delete();
        prev_end = 0;
        #1;
        check_output("rst_mid_valid", valid_out, 0);
        check_output("rst_mid_count", fifo_count, 0);
        repeat (2) @(negedge clk_32f);
        #1 reset = 1'b1;
        apply_stimulus(32'hA1B2_C3D4, 1'b0);
        wait_idle();

        $display("[TB] random traffic");
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_32f);
            #1;
            valid_in = 1'($urandom_range(0, 1));
            data_in  = $urandom;
            if ($urandom_range(0, 7) == 0) x1_mode = ~x1_mode;
        end
        valid_in = 1'b0;
        x1_mode  = 1'b0;
        wait_idle();

        $display("[TB] 64-bit / 4-lane back-to-back");
        for (int i = 0; i < 6; i++) begin
            bit ok;
            ok = 1'b0;
            data_in_b  = (i < 2) ? {burst[2*i], burst[2*i+1]} : {$urandom, $urandom};
            valid_in_b = 1'b1;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk_32f);
                if (ready_in_b) begin
                    ok = 1'b1;
                    break;
                end
            end
            check_output("b_ready_wait", ok, 1);
            @(posedge clk_32f);
            #1;
        end
        valid_in_b = 1'b0;
        wait_idle();

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
